// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 (CPOL=0, CPHA=0) transmit-only master.
//   Bytes are queued in a small FIFO. Each byte goes out as its own CS frame, MSB
//   first, with programmable SCLK rate and CS setup/hold/gap timing. Single clk domain.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tx_data/tx_valid  byte to queue; accepted when tx_valid && tx_ready
//   tx_ready          FIFO not full
//   busy              frame in progress or FIFO non-empty
//   frame_done        1-cycle pulse as a frame's CS gap ends
//   spi_sclk/spi_mosi/spi_cs_n  registered SPI outputs
module spi_master_tx #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              spi_cs_n
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(DATA_W);
  localparam int CMAX = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_GAP));
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t state, state_nxt;

  // ---------------- FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              empty, full, push, pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign push     = tx_valid && !full;
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign tx_ready = !full;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // ---------------- FSM ----------------
  // cnt is shared: SETUP/HOLD/GAP duration, and the SCLK half-period inside SHIFT.
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DATA_W-2:0]   shreg;   // bits still to send after the one on mosi
  logic                half_end, last_bit;

  assign half_end = (cnt == CW'(CLK_DIV-1));
  assign last_bit = (bit_cnt == BW'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (!empty) begin
               pop       = 1'b1;
               state_nxt = SETUP;
             end
      SETUP: if (cnt == CW'(CS_SETUP-1)) state_nxt = SHIFT;
      SHIFT: if (half_end && !spi_sclk && last_bit) state_nxt = HOLD;
      HOLD:  if (cnt == CW'(CS_HOLD-1)) state_nxt = GAP;
      GAP:   if (cnt == CW'(CS_GAP-1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath / SPI outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (state_nxt != state || state == IDLE || (state == SHIFT && half_end))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      case (state)
        IDLE: if (pop) begin
          shreg    <= rd_data[DATA_W-2:0];
          spi_mosi <= rd_data[DATA_W-1];
          spi_cs_n <= 1'b0;
          bit_cnt  <= '0;
        end
        SETUP: if (state_nxt == SHIFT) spi_sclk <= 1'b1;
        SHIFT: if (half_end) begin
          if (spi_sclk) begin
            // falling edge: present next bit for the coming high phase
            spi_sclk <= 1'b0;
            if (!last_bit) begin
              spi_mosi <= shreg[DATA_W-2];
              shreg    <= shreg << 1;
            end
          end else if (!last_bit) begin
            spi_sclk <= 1'b1;
            bit_cnt  <= bit_cnt + BW'(1);
          end
        end
        HOLD: if (state_nxt == GAP) begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
        end
        GAP: if (state_nxt == IDLE) frame_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx. The reference model predicts every output cycle by cycle
// from the frame-offset arithmetic (setup, 2*CLK_DIV per bit, hold, gap) and a byte
// queue; a serial slave reassembles frames for scoreboard comparison.
module tb_spi_master_tx;
  localparam int DW = 8, DEPTH = 4, CDIV = 4, SU = 2, HO = 2, GP = 2;
  localparam int SHL    = 2*DW*CDIV;
  localparam int LOWLEN = SU + SHL + HO;
  localparam int PERIOD = 1 + LOWLEN + GP;

  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, frame_done, spi_sclk, spi_mosi, spi_cs_n;
  logic [DW-1:0] f_data = '0;
  logic f_valid = 1'b0;
  logic f_ready, f_busy, f_done, f_sclk, f_mosi, f_cs_n;

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(CDIV), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
                  .CS_SETUP(SU), .CS_HOLD(HO), .CS_GAP(GP)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n));

  spi_master_tx #(.CLK_DIV(1), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
                  .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut_f (
    .clk(clk), .rst(rst), .tx_data(f_data), .tx_valid(f_valid), .tx_ready(f_ready),
    .busy(f_busy), .frame_done(f_done), .spi_sclk(f_sclk), .spi_mosi(f_mosi),
    .spi_cs_n(f_cs_n));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] mq[$], sent[$], rxq[$];
  logic [DW-1:0] cur = '0;
  int  cyc = 0, start = 0;
  bit  active = 1'b0;
  // slave / monitor state
  bit  prev_cs = 1'b1, prev_sclk = 1'b0;
  int  nb = 0, partials = 0, fd_cnt = 0, run = 0;
  logic [DW-1:0] sh = '0;
  bit  gap_chk = 1'b0, gap_arm = 1'b0;
  logic [DW-1:0] burst [5];

  task automatic tick();
    bit pop, push;
    int o, idx;
    logic e_cs, e_sclk, e_mosi, e_fd, e_busy, e_rdy;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete(); sent.delete(); active = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && (!active || cyc - start >= PERIOD);
      push = tx_valid && (mq.size() < DEPTH);
      if (pop)  begin cur = mq.pop_front(); start = cyc; active = 1'b1; end
      if (push) begin mq.push_back(tx_data); sent.push_back(tx_data); end
    end
    o      = cyc - start;
    e_cs   = !(active && o < LOWLEN);
    e_sclk = active && o >= SU && o < SU + SHL && (((o - SU) / CDIV) % 2 == 0);
    e_mosi = 1'b0;
    if (active && o < LOWLEN) begin
      idx = (o < SU) ? 0 : (o - SU + CDIV) / (2*CDIV);
      if (idx > DW-1) idx = DW-1;
      e_mosi = cur[DW-1-idx];
    end
    e_fd   = active && o == PERIOD-1;
    e_busy = (mq.size() > 0) || (active && o < PERIOD-1);
    e_rdy  = mq.size() < DEPTH;
    @(negedge clk);
    chk("cs_n", spi_cs_n, e_cs);
    chk("sclk", spi_sclk, e_sclk);
    chk("mosi", spi_mosi, e_mosi);
    chk("frame_done", frame_done, e_fd);
    chk("busy", busy, e_busy);
    chk("tx_ready", tx_ready, e_rdy);
    // serial slave: sample on SCLK rise, close frame on CS rise
    if (!prev_sclk && spi_sclk === 1'b1 && spi_cs_n === 1'b0) begin
      sh = {sh[DW-2:0], spi_mosi}; nb++;
    end
    if (spi_cs_n === 1'b1) begin
      if (!prev_cs) begin
        if (nb == DW) rxq.push_back(sh); else partials++;
        nb = 0; gap_arm = gap_chk; run = 1;
      end else run++;
    end else if (prev_cs) begin
      if (gap_arm) chk("cs_gap", run, GP+1);
      gap_arm = 1'b0;
    end
    if (frame_done === 1'b1) fd_cnt++;
    prev_cs   = (spi_cs_n === 1'b1);
    prev_sclk = (spi_sclk === 1'b1);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((busy !== 1'b0 || spi_cs_n !== 1'b1) && n < limit) begin tick(); n++; end
    chk("drain_timeout", busy, 1'b0);
    tick();
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_cnt"}, rxq.size(), sent.size());
    for (int k = 0; k < rxq.size() && k < sent.size(); k++)
      chk({tag, "_data"}, rxq[k], sent[k]);
    rxq.delete(); sent.delete();
  endtask

  initial begin
    int n, i, guard, rises, highs, viol;
    bit acc, fprev;
    logic [DW-1:0] fsh;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h80; burst[3] = 8'h01; burst[4] = 8'h3C;

    // 1: reset held 3 cycles
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("t1_fd", fd_cnt, 0);
    chk("t1_f_ready", f_ready, 1'b1);
    chk("t1_f_cs", f_cs_n, 1'b1);

    // 2: single byte, latency and frame length
    fd_cnt = 0;
    tx_data = 8'hA5; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    tick();
    chk("t2_cs_low", spi_cs_n, 1'b0);
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("t2_fd_lat", n, PERIOD-1);
    drain(200);
    chk("t2_fd_cnt", fd_cnt, 1);
    chk("t2_byte", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'hA5);
    check_rx("t2");

    // 3: back-to-back burst, CS gap between frames
    fd_cnt = 0; gap_chk = 1'b1; i = 0; guard = 0; tx_valid = 1'b1;
    while (i < 5 && guard < 500) begin
      tx_data = burst[i];
      acc = mq.size() < DEPTH;
      tick(); guard++;
      if (acc) i++;
    end
    tx_valid = 1'b0;
    chk("t3_accepted", i, 5);
    chk("t3_ready_full", tx_ready, mq.size() < DEPTH);
    drain(1000);
    gap_chk = 1'b0; gap_arm = 1'b0;
    chk("t3_fd_cnt", fd_cnt, 5);
    check_rx("t3");

    // 4: fastest timing on the second instance
    f_data = 8'h7E; f_valid = 1'b1; tick(); f_valid = 1'b0;
    n = 0;
    while (f_cs_n !== 1'b0 && n < 10) begin tick(); n++; end
    chk("t4_cs_lat", n, 1);
    rises = 0; highs = 0; viol = 0; fsh = '0; fprev = 1'b0; n = 0;
    while (f_done !== 1'b1 && n < 100) begin
      tick(); n++;
      if (f_sclk === 1'b1) begin
        highs++;
        if (!fprev) begin rises++; fsh = {fsh[DW-2:0], f_mosi}; end
        if (f_cs_n !== 1'b0) viol++;
      end
      fprev = (f_sclk === 1'b1);
    end
    chk("t4_period", n + 1, 20);
    chk("t4_rises", rises, DW);
    chk("t4_highs", highs, DW);
    chk("t4_sclk_cs", viol, 0);
    chk("t4_byte", fsh, 8'h7E);
    tick();
    chk("t4_idle", f_busy, 1'b0);

    // 5: reset during bit 3 of 0xC3 with more bytes queued
    fd_cnt = 0; partials = 0; i = 0; guard = 0; tx_valid = 1'b1;
    while (i < 3 && guard < 50) begin
      tx_data = (i == 0) ? 8'hC3 : 8'(8'h11 * i);
      acc = mq.size() < DEPTH;
      tick(); guard++;
      if (acc) i++;
    end
    tx_valid = 1'b0;
    n = 0;
    while (!(active && cyc - start == SU + 3*2*CDIV + 1) && n < 300) begin tick(); n++; end
    chk("t5_in_bit3", spi_sclk, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_cs", spi_cs_n, 1'b1);
    chk("t5_sclk", spi_sclk, 1'b0);
    chk("t5_flushed", busy, 1'b0);
    repeat (5) tick();
    chk("t5_no_fd", fd_cnt, 0);
    chk("t5_partial", partials, 1);
    tx_data = 8'h55; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    drain(200);
    chk("t5_fd", fd_cnt, 1);
    check_rx("t5");

    // 6: random bytes, tx_valid held through full periods
    partials = 0; i = 0; guard = 0;
    tx_data = 8'($urandom); tx_valid = 1'b1;
    while (i < 24 && guard < 5000) begin
      acc = tx_valid && mq.size() < DEPTH;
      tick(); guard++;
      if (acc) begin
        i++;
        tx_data  = 8'($urandom);
        tx_valid = ($urandom_range(0, 3) != 0);
      end else if (!tx_valid) tx_valid = ($urandom_range(0, 1) != 0);
    end
    tx_valid = 1'b0;
    chk("t6_pushed", i, 24);
    drain(3000);
    chk("t6_partial", partials, 0);
    check_rx("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
